// File: rtl/noc_ni_packetizer_if.sv
// noc_ni_packetizer_if: request, payload and router-side bundle for the
// NI packetizer; master = packetizer, slave = IP core / router side.
`timescale 1ns/1ps

interface noc_ni_packetizer_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic [6:0]            req_dest_x;
   logic [6:0]            req_dest_y;
   logic [3:0]            req_len_m1;
   logic [DATA_WIDTH-1:0] pl_data;
   logic                  pl_valid;
   logic                  pl_ready;
   logic [DATA_WIDTH-1:0] noc_data;
   logic                  noc_valid;
   logic                  noc_last;
   logic                  noc_ready;
   logic                  busy;
   logic [15:0]           pkt_cnt;

   modport master (
      input  req_valid, req_dest_x, req_dest_y, req_len_m1,
      input  pl_data, pl_valid, noc_ready,
      output req_ready, pl_ready,
      output noc_data, noc_valid, noc_last,
      output busy, pkt_cnt
   );

   modport slave (
      output req_valid, req_dest_x, req_dest_y, req_len_m1,
      output pl_data, pl_valid, noc_ready,
      input  req_ready, pl_ready,
      input  noc_data, noc_valid, noc_last,
      input  busy, pkt_cnt
   );
endinterface

// File: rtl/noc_ni_packetizer.sv
// noc_ni_packetizer: NI injection stage, header + payload flits to router.
// Optional macro NI_TAIL_CHECKSUM_EN appends an XOR tail flit per packet.
`timescale 1ns/1ps

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module noc_ni_packetizer #(
   parameter int X_CUR      = 2,
   parameter int Y_CUR      = 2,
   parameter int DATA_WIDTH = `DATA_WIDTH
) (
   input logic                 clk,
   input logic                 nreset,
   noc_ni_packetizer_if.master ni
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_HDR  = 3'd1,
      S_PLD  = 3'd2,
      S_DONE = 3'd3
`ifdef NI_TAIL_CHECKSUM_EN
      ,
      S_TAIL = 3'd4
`endif
   } state_t;

   state_t                r_state;
   state_t                w_next;

   logic [6:0]            r_dx;
   logic [6:0]            r_dy;
   logic [3:0]            r_len;
   logic [3:0]            r_wcnt;
   logic [15:0]           r_pkt_cnt;
   logic                  r_armed;

   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_valid;
   logic                  r_last;

`ifdef NI_TAIL_CHECKSUM_EN
   logic [DATA_WIDTH-1:0] r_acc;
`endif

   logic                  w_load;
   logic                  w_req_ready;
   logic                  w_pl_ready;
   logic                  w_req_hs;
   logic                  w_pl_hs;
   logic                  w_is_end;
   logic                  w_out_done;
   logic                  w_fvld;
   logic                  w_flast;
   logic [DATA_WIDTH-1:0] w_fdata;
   logic [DATA_WIDTH-1:0] w_hdr;

   assign w_load     = !r_valid || ni.noc_ready;
   assign w_req_hs   = ni.req_valid && w_req_ready;
   assign w_pl_hs    = ni.pl_valid && w_pl_ready;
   assign w_is_end   = (r_wcnt == r_len);
   assign w_out_done = r_valid && ni.noc_ready && r_last;

   assign ni.req_ready = w_req_ready;
   assign ni.pl_ready  = w_pl_ready;
   assign ni.noc_data  = r_data;
   assign ni.noc_valid = r_valid;
   assign ni.noc_last  = r_last;
   assign ni.pkt_cnt   = r_pkt_cnt;
   assign ni.busy      = (r_state != S_IDLE) || r_valid;

   // header flit assembled from the latched request and router position
   always_comb begin
      w_hdr        = '0;
      w_hdr[6:0]   = r_dx;
      w_hdr[13:7]  = r_dy;
      w_hdr[20:14] = 7'(X_CUR);
      w_hdr[27:21] = 7'(Y_CUR);
      w_hdr[31:28] = r_len;
   end

   // FSM state register
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   // FSM next-state logic
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: if (w_req_hs) w_next = S_HDR;
         S_HDR:  if (w_load)   w_next = S_PLD;
         S_PLD: begin
            if (w_pl_hs && w_is_end) begin
`ifdef NI_TAIL_CHECKSUM_EN
               w_next = S_TAIL;
`else
               w_next = S_DONE;
`endif
            end
         end
`ifdef NI_TAIL_CHECKSUM_EN
         S_TAIL: if (w_load) w_next = S_DONE;
`endif
         S_DONE: if (w_out_done) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // FSM outputs: handshake readies and the flit offered to the output reg
   always_comb begin
      w_req_ready = 1'b0;
      w_pl_ready  = 1'b0;
      w_fvld      = 1'b0;
      w_flast     = 1'b0;
      w_fdata     = '0;
      unique case (r_state)
         S_IDLE: w_req_ready = w_load && r_armed;
         S_HDR: begin
            w_fvld  = 1'b1;
            w_fdata = w_hdr;
         end
         S_PLD: begin
            w_pl_ready = w_load;
            w_fvld     = ni.pl_valid;
            w_fdata    = ni.pl_data;
`ifdef NI_TAIL_CHECKSUM_EN
            w_flast    = 1'b0;
`else
            w_flast    = w_is_end;
`endif
         end
`ifdef NI_TAIL_CHECKSUM_EN
         S_TAIL: begin
            w_fvld  = 1'b1;
            w_fdata = r_acc;
            w_flast = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   // output register: advances only when empty or drained by the router
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_valid <= 1'b0;
         r_last  <= 1'b0;
         r_data  <= '0;
      end else if (w_load) begin
         r_valid <= w_fvld;
         r_last  <= w_fvld && w_flast;
         if (w_fvld) r_data <= w_fdata;
      end
   end

   // request latch, word counter and packet counter
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_dx      <= '0;
         r_dy      <= '0;
         r_len     <= '0;
         r_wcnt    <= '0;
         r_pkt_cnt <= '0;
         r_armed   <= 1'b0;
      end else begin
         r_armed <= 1'b1;
         if (w_req_hs) begin
            r_dx  <= ni.req_dest_x;
            r_dy  <= ni.req_dest_y;
            r_len <= ni.req_len_m1;
         end
         if (r_state == S_HDR && w_load) r_wcnt <= '0;
         else if (w_pl_hs)               r_wcnt <= r_wcnt + 4'd1;
         if (r_state == S_DONE && w_out_done)
            r_pkt_cnt <= r_pkt_cnt + 16'd1;
      end
   end

`ifdef NI_TAIL_CHECKSUM_EN
   // running XOR of the payload words for the tail flit
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset)                    r_acc <= '0;
      else if (r_state == S_HDR && w_load) r_acc <= '0;
      else if (w_pl_hs)               r_acc <= r_acc ^ ni.pl_data;
   end
`endif

endmodule
